// File: rtl/gf180mcu_fd_sc_demux_pkg.sv
// Shared definitions for the registered demultiplexer family.
// Holds the select-width helper, the lane-index type and the lane-count ceiling.
package gf180mcu_fd_sc_demux_pkg;

    localparam int N_OUT_MAX = 16;

    // Bits needed to encode values 0..value-1 (minimum width of a select for value lanes).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    typedef logic [clog2(N_OUT_MAX)-1:0] lane_idx_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux_reg_if.sv
// Producer/consumer bundle of the registered demultiplexer.
// The master side drives the input word and lane readies; the slave side is the demux.
interface gf180mcu_fd_sc_mcu7t5v0__demux_reg_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
);

    logic [WIDTH-1:0]       I;
    logic                   I_VALID;
    logic                   I_READY;
    logic [SEL_W-1:0]       S;
    logic                   RR_EN;
    logic [N_OUT*WIDTH-1:0] Z;
    logic [N_OUT-1:0]       Z_VALID;
    logic [N_OUT-1:0]       Z_READY;
    logic [SEL_W-1:0]       PTR;
    logic                   SEL_ERR;

    modport master (
        output I, I_VALID, S, RR_EN, Z_READY,
        input  I_READY, Z, Z_VALID, PTR, SEL_ERR
    );

    modport slave (
        input  I, I_VALID, S, RR_EN, Z_READY,
        output I_READY, Z, Z_VALID, PTR, SEL_ERR
    );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux_lane.sv
// One output lane: a single-entry word register with its valid flag.
// A load wins over a drain, so a lane can be refilled in the cycle it is emptied.
module gf180mcu_fd_sc_mcu7t5v0__demux_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (!rn) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            data_out <= data_in;
            valid    <= 1'b1;
        end else if (valid && ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux_reg.sv
// Registered 1-to-N demultiplexer with addressed or round-robin lane selection.
// Holds the target decode, the accept logic and the round-robin pointer.
module gf180mcu_fd_sc_mcu7t5v0__demux_reg
    import gf180mcu_fd_sc_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = clog2(N_OUT)
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu7t5v0__demux_reg_if.slave bus
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] tgt;
    logic             sel_err;
    logic             i_ready;
    logic             acc;
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] lane_blocked;

    assign tgt     = bus.RR_EN ? ptr : bus.S;
    assign sel_err = !bus.RR_EN && (32'(bus.S) >= 32'(N_OUT));

    // The target is decoded per lane, so an out-of-range S never indexes past the lanes.
    assign i_ready = !sel_err && !(|lane_blocked);
    assign acc     = bus.I_VALID && i_ready;

    assign bus.I_READY = i_ready;
    assign bus.SEL_ERR = sel_err;
    assign bus.PTR     = ptr;

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        logic hit;
        assign hit             = (lane_idx_t'(tgt) == lane_idx_t'(k));
        assign lane_blocked[k] = hit && bus.Z_VALID[k] && !bus.Z_READY[k];
        assign load[k]         = hit && acc;

        gf180mcu_fd_sc_mcu7t5v0__demux_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk      (CLK),
            .rn       (RN),
            .load     (load[k]),
            .data_in  (bus.I),
            .ready    (bus.Z_READY[k]),
            .data_out (bus.Z[k*WIDTH +: WIDTH]),
            .valid    (bus.Z_VALID[k])
        );
    end

    // The pointer only advances on a round-robin accept, so a full lane stalls it in place.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            ptr <= '0;
        end else if (acc && bus.RR_EN) begin
            ptr <= (ptr == SEL_W'(N_OUT - 1)) ? '0 : ptr + SEL_W'(1);
        end
    end

endmodule
